// File: rtl/cpu_pkg.sv
// Shared CPU-side types and default widths for the memory arbiter and related FSMs.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned MEM_LAT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/lat_counter.sv
// Loadable saturating down-counter with a zero flag, used to time fixed-latency accesses.
module lat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero_c
);

  // Load wins over decrement; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between fetch (I) and data (D) ports.
// D has priority; an in-flight fetch can be squashed but still runs its full latency.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_done,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned     CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               SINGLE   = (MEM_LAT == 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero_c;
  logic             grant_d_c;
  logic             grant_i_c;
  logic             load_c;
  logic             last_nxt_c;
  logic             squash;
  logic             squash_nxt_c;

  lat_counter #(
    .W(CNT_W)
  ) u_lat_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_c),
    .load_val(LOAD_VAL),
    .dec     (state != IDLE),
    .cnt     (cnt),
    .zero_c  (cnt_zero_c)
  );

  // Next-state, grant and squash decode; last_nxt_c flags that the coming cycle is the final one.
  always_comb begin
    state_nxt    = state;
    grant_d_c    = 1'b0;
    grant_i_c    = 1'b0;
    squash_nxt_c = squash;
    unique case (state)
      IDLE: begin
        if (d_req) begin
          state_nxt = BUSY_D;
          grant_d_c = 1'b1;
        end else if (i_req && !i_flush) begin
          state_nxt = BUSY_I;
          grant_i_c = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_zero_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    load_c     = grant_d_c | grant_i_c;
    last_nxt_c = load_c ? SINGLE : ((state != IDLE) && (cnt == CNT_ONE));
    if (state_nxt == IDLE) begin
      squash_nxt_c = 1'b0;
    end else if ((state == BUSY_I) && i_flush) begin
      squash_nxt_c = 1'b1;
    end
  end

  // State, latches and registered strobes; outputs are computed from next-state so they align with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      squash    <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      state  <= state_nxt;
      squash <= squash_nxt_c;
      busy   <= (state_nxt != IDLE);
      mem_en <= (state_nxt != IDLE);
      d_done <= (state_nxt == BUSY_D) && last_nxt_c;
      i_done <= (state_nxt == BUSY_I) && last_nxt_c && !squash_nxt_c;
      if (grant_d_c) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_wr    <= d_wr;
      end else if (grant_i_c) begin
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        mem_wr    <= 1'b0;
      end else if (state_nxt == IDLE) begin
        mem_wr <= 1'b0;
      end
    end
  end

  // Read data is only valid in the final cycle, so it is forwarded straight from memory.
  assign i_data  = i_done ? mem_rdata : '0;
  assign d_rdata = (d_done && !mem_wr) ? mem_rdata : '0;

endmodule
